// File: rtl/floor_counter_scheduler_pkg.sv
// Shared constants for the elevator floor-counter scheduler and the counter it drives.
package floor_counter_scheduler_pkg;

  localparam int unsigned FLOOR_W = 4;

  localparam logic [1:0] MODO_UP   = 2'b00;
  localparam logic [1:0] MODO_DOWN = 2'b01;
  localparam logic [1:0] MODO_LOAD = 2'b11;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_MOVE,
    S_STEP,
    S_ARRIVE,
    S_DOOR
  } state_t;

endpackage

// File: rtl/floor_counter_scheduler_request_reg.sv
// Latched floor calls plus the above/below/here summary relative to the current floor.
module floor_request_reg
  import floor_counter_scheduler_pkg::*;
#(
  parameter int unsigned N_FLOORS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_FLOORS-1:0] req_i,
  input  logic                clr_en_i,
  input  logic                look_req_i,
  input  logic [FLOOR_W-1:0]  floor_i,
  output logic [N_FLOORS-1:0] pending_o,
  output logic                above_o,
  output logic                below_o,
  output logic                here_o
);

  logic [N_FLOORS-1:0] pending_q;
  logic [N_FLOORS-1:0] pending_d;
  logic [N_FLOORS-1:0] clr_mask;
  logic [N_FLOORS-1:0] view;

  // look_req_i folds this cycle's calls into the decision without waiting for the latch.
  always_comb begin
    clr_mask = '0;
    view     = pending_q | (look_req_i ? req_i : '0);
    above_o  = 1'b0;
    below_o  = 1'b0;
    here_o   = 1'b0;
    for (int unsigned i = 0; i < N_FLOORS; i++) begin
      if (i == 32'(floor_i)) begin
        clr_mask[i] = clr_en_i;
        here_o      = view[i];
      end
      if (view[i]) begin
        if (i > 32'(floor_i)) above_o = 1'b1;
        if (i < 32'(floor_i)) below_o = 1'b1;
      end
    end
    pending_d = (pending_q | req_i) & ~clr_mask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/floor_counter_scheduler.sv
// SCAN-policy sequencer for the 4-bit floor counter: steps one floor per command, holds the door on arrival.
module floor_counter_scheduler
  import floor_counter_scheduler_pkg::*;
#(
  parameter int unsigned N_FLOORS    = 8,
  parameter int unsigned STEP_CYCLES = 4,
  parameter int unsigned DOOR_CYCLES = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_FLOORS-1:0] req,
  input  logic [FLOOR_W-1:0]  cnt_q,
  output logic                cnt_enb,
  output logic [1:0]          cnt_modo,
  output logic [FLOOR_W-1:0]  cnt_data,
  output logic                door_open,
  output logic                busy,
  output logic                dir_up,
  output logic [N_FLOORS-1:0] pending
);

  localparam int unsigned TMAX = (STEP_CYCLES > DOOR_CYCLES) ? STEP_CYCLES : DOOR_CYCLES;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] STEP_LOAD = TW'(STEP_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LOAD = TW'(DOOR_CYCLES - 1);

  state_t              state_q;
  logic [TW-1:0]       timer_q;
  logic                dir_up_q;
  logic                cnt_enb_q;
  logic [1:0]          cnt_modo_q;
  logic [FLOOR_W-1:0]  cnt_data_q;
  logic                door_q;
  logic                busy_q;

  logic above, below, here, floor_valid, req_here;

  floor_request_reg #(
    .N_FLOORS (N_FLOORS)
  ) u_req (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req),
    .clr_en_i   (state_q == S_DOOR),
    .look_req_i (state_q == S_ARRIVE),
    .floor_i    (cnt_q),
    .pending_o  (pending),
    .above_o    (above),
    .below_o    (below),
    .here_o     (here)
  );

  always_comb begin
    floor_valid = (32'(cnt_q) < N_FLOORS);
    req_here    = 1'b0;
    for (int unsigned i = 0; i < N_FLOORS; i++) begin
      if (i == 32'(cnt_q)) req_here = req[i];
    end
  end

  // Outputs are registered on the transition into a state, so a command pulse
  // coincides exactly with the INIT/STEP cycle it belongs to; INIT after reset
  // spends one cycle raising the load pulse before it is seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_INIT;
      timer_q    <= '0;
      dir_up_q   <= 1'b1;
      cnt_enb_q  <= 1'b0;
      cnt_modo_q <= MODO_LOAD;
      cnt_data_q <= '0;
      door_q     <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      cnt_enb_q <= 1'b0;
      case (state_q)
        S_INIT: begin
          if (!cnt_enb_q) begin
            cnt_enb_q  <= 1'b1;
            cnt_modo_q <= MODO_LOAD;
            cnt_data_q <= '0;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_IDLE: begin
          if (!floor_valid) begin
            state_q    <= S_INIT;
            busy_q     <= 1'b1;
            cnt_enb_q  <= 1'b1;
            cnt_modo_q <= MODO_LOAD;
            cnt_data_q <= '0;
          end else if (here) begin
            state_q <= S_DOOR;
            busy_q  <= 1'b1;
            door_q  <= 1'b1;
            timer_q <= DOOR_LOAD;
          end else if (above || below) begin
            if (!(above && below)) dir_up_q <= above;
            state_q <= S_MOVE;
            busy_q  <= 1'b1;
            timer_q <= STEP_LOAD;
          end
        end
        S_MOVE: begin
          if (timer_q == '0) begin
            state_q    <= S_STEP;
            cnt_enb_q  <= 1'b1;
            cnt_modo_q <= dir_up_q ? MODO_UP : MODO_DOWN;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        S_STEP: state_q <= S_ARRIVE;
        S_ARRIVE: begin
          if (here) begin
            state_q <= S_DOOR;
            door_q  <= 1'b1;
            timer_q <= DOOR_LOAD;
          end else if (dir_up_q ? above : below) begin
            state_q <= S_MOVE;
            timer_q <= STEP_LOAD;
          end else if (dir_up_q ? below : above) begin
            dir_up_q <= ~dir_up_q;
            state_q  <= S_MOVE;
            timer_q  <= STEP_LOAD;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_DOOR: begin
          if (req_here) begin
            timer_q <= DOOR_LOAD;
          end else if (timer_q == '0) begin
            state_q <= S_IDLE;
            door_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign cnt_enb   = cnt_enb_q;
  assign cnt_modo  = cnt_modo_q;
  assign cnt_data  = cnt_data_q;
  assign door_open = door_q;
  assign busy      = busy_q;
  assign dir_up    = dir_up_q;

endmodule

// File: tb/tb_floor_counter_scheduler.sv
// Scoreboard bench: behavioural floor counter, expected command/door events queued by stimulus.
module tb_floor_counter_scheduler;
  import floor_counter_scheduler_pkg::*;

  localparam int EV_CMD  = 0;
  localparam int EV_DOOR = 1;

  typedef struct {
    int         kind;
    logic [1:0] modo;
    int         floor;
    int         len;   // CMD: cycles since previous command, DOOR: open cycles; 0 = not checked
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [3:0] cnt_q = 4'd5;
  logic       cnt_enb;
  logic [1:0] cnt_modo;
  logic [3:0] cnt_data;
  logic       door_open, busy, dir_up;
  logic [7:0] pending;
  logic       force_en;
  logic [3:0] force_val;

  int checks = 0;
  int errors = 0;
  ev_t exp_q[$];

  floor_counter_scheduler #(
    .N_FLOORS    (8),
    .STEP_CYCLES (4),
    .DOOR_CYCLES (6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .cnt_q     (cnt_q),
    .cnt_enb   (cnt_enb),
    .cnt_modo  (cnt_modo),
    .cnt_data  (cnt_data),
    .door_open (door_open),
    .busy      (busy),
    .dir_up    (dir_up),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (force_en) cnt_q <= force_val;
    else if (cnt_enb) begin
      case (cnt_modo)
        MODO_UP:   cnt_q <= cnt_q + 4'd1;
        MODO_DOWN: cnt_q <= cnt_q - 4'd1;
        MODO_LOAD: cnt_q <= cnt_data;
        default:   ;
      endcase
    end
  end

  task automatic push(input int kind, input logic [1:0] modo, input int floor, input int len);
    ev_t e;
    e.kind = kind; e.modo = modo; e.floor = floor; e.len = len;
    exp_q.push_back(e);
  endtask

  task automatic sb_compare(input string name, input ev_t got, input logic [3:0] data);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event kind=%0d modo=%b floor=%0d len=%0d", name, got.kind, got.modo, got.floor, got.len);
    end else begin
      e = exp_q.pop_front();
      if (got.kind != e.kind || got.floor != e.floor ||
          (e.kind == EV_CMD && got.modo != e.modo) ||
          (e.kind == EV_CMD && e.modo == MODO_LOAD && data != 4'd0) ||
          (e.len != 0 && got.len != e.len)) begin
        errors++;
        $display("FAIL %s: got kind=%0d modo=%b floor=%0d len=%0d data=%0d, required kind=%0d modo=%b floor=%0d len=%0d",
                 name, got.kind, got.modo, got.floor, got.len, data, e.kind, e.modo, e.floor, e.len);
      end
    end
  endtask

  int   cyc = 0, last_enb = 0, door_len = 0, door_floor = 0;
  logic door_prev = 1'b0;

  always @(negedge clk) begin
    ev_t got;
    cyc++;
    if (cnt_enb === 1'b1) begin
      got.kind = EV_CMD; got.modo = cnt_modo; got.floor = int'(cnt_q); got.len = cyc - last_enb;
      last_enb = cyc;
      sb_compare("cmd", got, cnt_data);
    end
    if (door_open === 1'b1 && !door_prev) begin
      door_floor = int'(cnt_q);
      door_len   = 0;
    end
    if (door_open === 1'b1) door_len++;
    if (door_open !== 1'b1 && door_prev) begin
      got.kind = EV_DOOR; got.modo = 2'b00; got.floor = door_floor; got.len = door_len;
      sb_compare("door", got, 4'd0);
    end
    door_prev = (door_open === 1'b1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout with %0d expected events outstanding", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic pulse_req(input int f);
    req    = '0;
    req[f] = 1'b1;
    @(negedge clk);
    req = '0;
  endtask

  initial begin
    int n;
    rst = 1'b1; req = '0; force_en = 1'b0; force_val = '0;
    repeat (2) @(negedge clk);
    chk("rst_enb",     32'(cnt_enb),   32'd0);
    chk("rst_modo",    32'(cnt_modo),  32'd3);
    chk("rst_data",    32'(cnt_data),  32'd0);
    chk("rst_door",    32'(door_open), 32'd0);
    chk("rst_busy",    32'(busy),      32'd1);
    chk("rst_dir",     32'(dir_up),    32'd1);
    chk("rst_pending", 32'(pending),   32'd0);

    push(EV_CMD, MODO_LOAD, 5, 0);
    rst = 1'b0;
    wait_idle("init");
    chk("init_floor", 32'(cnt_q), 32'd0);
    chk("init_busy",  32'(busy),  32'd0);

    // floor 0 -> 3
    push(EV_CMD, MODO_UP, 0, 0);
    push(EV_CMD, MODO_UP, 1, 6);
    push(EV_CMD, MODO_UP, 2, 6);
    push(EV_DOOR, 2'b00, 3, 6);
    pulse_req(3);
    wait_idle("up3");
    chk("up3_floor",   32'(cnt_q),   32'd3);
    chk("up3_pending", 32'(pending), 32'd0);

    // sweep up to 5 first, then reverse to 1
    push(EV_CMD, MODO_UP, 3, 0);
    push(EV_CMD, MODO_UP, 4, 6);
    push(EV_DOOR, 2'b00, 5, 6);
    push(EV_CMD, MODO_DOWN, 5, 13);
    push(EV_CMD, MODO_DOWN, 4, 6);
    push(EV_CMD, MODO_DOWN, 3, 6);
    push(EV_CMD, MODO_DOWN, 2, 6);
    push(EV_DOOR, 2'b00, 1, 6);
    req = 8'b0010_0010;
    @(negedge clk);
    req = '0;
    wait_idle("scan");
    chk("scan_floor", 32'(cnt_q),  32'd1);
    chk("scan_dir",   32'(dir_up), 32'd0);

    // door held open by repeated calls at floor 2 (last call 7 cycles in -> 14 open cycles)
    push(EV_CMD, MODO_UP, 1, 0);
    push(EV_DOOR, 2'b00, 2, 14);
    pulse_req(2);
    n = 0;
    while (door_open !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("door2_seen", 32'(door_open), 32'd1);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      req = 8'b0000_0100;
      @(negedge clk);
      req = '0;
      chk("door2_pend", 32'(pending[2]), 32'd0);
      if (k < 2) repeat (2) @(negedge clk);
    end
    wait_idle("door2");
    chk("door2_pending", 32'(pending), 32'd0);

    // reset during the 4->5 step
    push(EV_CMD, MODO_UP, 2, 0);
    push(EV_CMD, MODO_UP, 3, 6);
    push(EV_CMD, MODO_UP, 4, 6);
    pulse_req(5);
    n = 0;
    while (!(cnt_enb === 1'b1 && cnt_q == 4'd4) && n < 100) begin @(negedge clk); n++; end
    chk("step45_seen", 32'(cnt_enb), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_enb",  32'(cnt_enb),  32'd0);
    chk("mid_rst_modo", 32'(cnt_modo), 32'd3);
    chk("mid_rst_busy", 32'(busy),     32'd1);
    chk("mid_rst_pend", 32'(pending),  32'd0);
    @(negedge clk);
    chk("mid_rst_hold", 32'(cnt_q), 32'd4);
    push(EV_CMD, MODO_LOAD, 4, 0);
    rst = 1'b0;
    wait_idle("rst_reload");
    chk("rst_reload_floor", 32'(cnt_q),  32'd0);
    chk("rst_reload_dir",   32'(dir_up), 32'd1);

    // out-of-range floor forces a reload
    push(EV_CMD, MODO_LOAD, 12, 0);
    force_val = 4'hC; force_en = 1'b1;
    @(negedge clk);
    force_en = 1'b0;
    @(negedge clk);
    chk("oor_enb",  32'(cnt_enb),  32'd1);
    chk("oor_modo", 32'(cnt_modo), 32'd3);
    wait_idle("oor");
    chk("oor_floor", 32'(cnt_q), 32'd0);

    // boundaries: calls at the current end floor open the door without a step
    push(EV_DOOR, 2'b00, 0, 6);
    pulse_req(0);
    wait_idle("b0");
    for (int f = 0; f < 7; f++) push(EV_CMD, MODO_UP, f, (f == 0) ? 0 : 6);
    push(EV_DOOR, 2'b00, 7, 6);
    pulse_req(7);
    wait_idle("to7");
    push(EV_DOOR, 2'b00, 7, 6);
    pulse_req(7);
    wait_idle("b7");
    for (int f = 7; f > 0; f--) push(EV_CMD, MODO_DOWN, f, (f == 7) ? 0 : 6);
    push(EV_DOOR, 2'b00, 0, 6);
    pulse_req(0);
    wait_idle("to0");
    chk("end_floor", 32'(cnt_q), 32'd0);

    repeat (10) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
